sd_sector_writer: RTL and testbench
===================================

SD_SECTOR_WRITER -- requirements
Module: sd_sector_writer

Packs 16-bit audio samples into 512-byte sectors, writes them through the SD controller write port, and terminates the recording with an end marker.

Interface
REQ-001 ADDR_INC, default 512, SHALL be the byte-address increment applied after each sector is written.
REQ-002 clk  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL be a one-cycle pulse that begins a recording.
REQ-005 stop  input  1  SHALL be a one-cycle pulse that ends a recording.
REQ-006 start_address  input  32  SHALL be the SD byte address of the first sector; it is sampled on start.
REQ-007 sample_in  input  16  SHALL be the signed audio sample.
REQ-008 sample_valid  input  1  SHALL mean sample_in is valid.
REQ-009 sample_ready  output  1  SHALL mean the block accepts sample_in; a transfer occurs on any cycle where sample_valid and sample_ready are both 1.
REQ-010 sd_ready  input  1  SHALL mean the SD controller is idle.
REQ-011 sd_ready_for_next_byte  input  1  SHALL be the controller's byte-consume strobe.
REQ-012 sd_wr  output  1  SHALL be the sector write command.
REQ-013 sd_din  output  8  SHALL be the byte offered to the controller.
REQ-014 sd_address  output  32  SHALL be the byte address of the current sector.
REQ-015 busy  output  1  SHALL be 1 in every state except IDLE and DONE.
REQ-016 done  output  1  SHALL be 1 while the block is in DONE.
REQ-017 sectors_written  output  16  SHALL be the count of completed sector writes.

Function
REQ-018 States SHALL be IDLE, FILL, ISSUE, SEND, FINISH, FLUSH, MARK, DONE.
REQ-019 IDLE: start SHALL latch start_address into sd_address, clear sectors_written, clear the fill index, and go to FILL; stop in IDLE SHALL be ignored.
REQ-020 FILL: sample_ready SHALL be 1, and sample_ready SHALL be 0 in every other state.
- Each accepted sample goes into a 256x16 buffer at the fill index, and the fill index increments.
- On the 256th sample the block goes to ISSUE.
REQ-021 Byte order SHALL be little-endian: byte 2k = sample[k][7:0], byte 2k+1 = sample[k][15:8].
REQ-022 ISSUE: the block SHALL wait for sd_ready=1, then assert sd_wr for exactly one cycle, with sd_address stable, and go to SEND.
REQ-023 SEND: sd_din SHALL present the byte at the byte index, starting at byte 0.
- The byte index advances only on a 0->1 edge of sd_ready_for_next_byte, detected with a registered copy of that signal.
- A strobe held high for several cycles SHALL advance the index once.
REQ-024 After the 512th edge, the block SHALL go to FINISH.
REQ-025 FINISH: the block SHALL wait for sd_ready=1, then on one clock edge:
- add ADDR_INC to sd_address (mod 2^32);
- increment sectors_written (wraps at 16 bits);
- clear the fill index.
REQ-026 The state after FINISH SHALL be:
- FILL, if no stop is pending;
- MARK, if the stop-pending flag is set and the marker has not yet been written;
- DONE, if the marker has been written.
REQ-027 A stop pulse received in FILL, ISSUE or SEND SHALL set the stop-pending flag; a stop in FILL takes effect (goes to FLUSH) on the cycle after it is seen.
REQ-028 A stop pulse coinciding with an accepted sample SHALL keep that sample.
REQ-029 FLUSH: the end marker is bytes FE, E1, DE, AD in that order, then zero padding to byte 511.
- If filled bytes ≤ 508: the marker is appended directly after the data and the block goes to ISSUE; one sector results.
- If filled bytes > 508: the remainder of the current sector is zero-padded, that sector is written, and the marker goes in a following sector.
REQ-030 MARK: the block SHALL write a sector holding the marker at bytes 0-3 and zeros at bytes 4-511.
REQ-031 A stop with zero samples filled SHALL still produce exactly one marker sector.
REQ-032 DONE: the block SHALL hold until start, which begins a new recording exactly as from IDLE.
REQ-033 The sector buffer SHALL be a single buffer; no samples are accepted while a sector is being written.

Reset
REQ-034 Asserting reset SHALL immediately force the following, regardless of state:
- IDLE; sd_wr=0; sample_ready=0; busy=0; done=0;
- sd_din=0; sd_address=0; sectors_written=0;
- stop-pending flag, marker-written flag and all indices cleared.
REQ-035 Reset mid-SEND SHALL abandon the sector; no further sd_wr is issued until a new start.
REQ-036 Buffer contents need not be reset.

Verification
REQ-037 Reset check: assert reset mid-operation -> all outputs take their REQ-034 values in the same cycle.
REQ-038 Full sector: start_address=0x1000, samples 0x0001..0x0100 ->
- one sd_wr pulse with sd_address=0x1000;
- bytes 01 00 02 00 ... 00 01;
- afterwards sd_address=0x1200 and sectors_written=1.
REQ-039 Short recording: 3 samples (0x1234, 0x5678, 0x9ABC), then stop ->
- one sector: 34 12 78 56 BC 9A FE E1 DE AD followed by 502 zeros;
- then done=1 and sectors_written=1.
REQ-040 Marker overflow: 255 samples, then stop ->
- sector 0: 510 data bytes + 2 zeros;
- sector 1: FE E1 DE AD + 508 zeros;
- sectors_written=2, sd_address=start_address+1024.
REQ-041 Reset during SEND after 100 bytes -> no further sd_wr, and a subsequent start restarts cleanly at the new start_address.
REQ-042 Held strobe: sd_ready_for_next_byte held high for 5 cycles per byte -> exactly 512 bytes are consumed; the bench checks each byte's value against the expected sequence.

Source files
------------

// File: rtl/sd_sector_writer.sv
// Packs 16-bit samples into 512-byte sectors, streams them to an SD write port and
// closes each recording with an FE E1 DE AD end marker.
module sd_sector_writer #(
    parameter int unsigned ADDR_INC = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] start_address,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        sd_ready,
    input  logic        sd_ready_for_next_byte,
    output logic        sd_wr,
    output logic [7:0]  sd_din,
    output logic [31:0] sd_address,
    output logic        busy,
    output logic        done,
    output logic [15:0] sectors_written
);

    typedef enum logic [2:0] {
        StIdle, StFill, StIssue, StSend, StFinish, StFlush, StMark, StDone
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] buffer [256];
    logic [8:0]  fill_idx_q;
    logic [8:0]  byte_idx_q;
    logic        strobe_q;
    logic        stop_pend_q;
    logic        mark_written_q;
    logic        mark_here_q;
    logic [31:0] address_q;
    logic [15:0] count_q;

    logic        accept;
    logic        byte_edge;
    logic [9:0]  data_bytes;
    logic [9:0]  tail_off;
    logic [15:0] rd_word;

    assign accept          = (state_q == StFill) && sample_valid;
    assign byte_edge       = sd_ready_for_next_byte && !strobe_q;
    assign sd_address      = address_q;
    assign sectors_written = count_q;
    assign busy            = (state_q != StIdle) && (state_q != StDone);
    assign done            = (state_q == StDone);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        sd_wr        = 1'b0;
        sample_ready = 1'b0;
        case (state_q)
            StIdle, StDone: if (start) state_d = StFill;
            StFill: begin
                sample_ready = 1'b1;
                if (accept && fill_idx_q == 9'd255) state_d = StIssue;
                else if (stop)                      state_d = StFlush;
            end
            StIssue: begin
                if (sd_ready) begin
                    sd_wr   = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: if (byte_edge && byte_idx_q == 9'd511) state_d = StFinish;
            StFinish: begin
                if (sd_ready) begin
                    if (mark_written_q)   state_d = StDone;
                    else if (stop_pend_q) state_d = StMark;
                    else                  state_d = StFill;
                end
            end
            StFlush, StMark: state_d = StIssue;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_idx_q     <= '0;
            byte_idx_q     <= '0;
            strobe_q       <= 1'b0;
            stop_pend_q    <= 1'b0;
            mark_written_q <= 1'b0;
            mark_here_q    <= 1'b0;
            address_q      <= '0;
            count_q        <= '0;
        end else begin
            strobe_q <= sd_ready_for_next_byte;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        address_q      <= start_address;
                        count_q        <= '0;
                        fill_idx_q     <= '0;
                        stop_pend_q    <= 1'b0;
                        mark_written_q <= 1'b0;
                        mark_here_q    <= 1'b0;
                    end
                end
                StFill: begin
                    if (accept) fill_idx_q <= fill_idx_q + 9'd1;
                    if (stop)   stop_pend_q <= 1'b1;
                end
                StIssue: begin
                    byte_idx_q <= '0;
                    if (stop) stop_pend_q <= 1'b1;
                end
                StSend: begin
                    if (byte_edge) byte_idx_q <= byte_idx_q + 9'd1;
                    if (stop)      stop_pend_q <= 1'b1;
                end
                StFinish: begin
                    if (sd_ready) begin
                        address_q   <= address_q + 32'(ADDR_INC);
                        count_q     <= count_q + 16'd1;
                        fill_idx_q  <= '0;
                        mark_here_q <= 1'b0;
                    end
                end
                StFlush: begin
                    // Marker fits behind the data only if 4 bytes remain.
                    if (fill_idx_q <= 9'd254) begin
                        mark_here_q    <= 1'b1;
                        mark_written_q <= 1'b1;
                    end
                end
                StMark: begin
                    mark_here_q    <= 1'b1;
                    mark_written_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) buffer[fill_idx_q[7:0]] <= sample_in;
    end

    // Bytes past the filled data read as marker (if placed here) or zero padding.
    always_comb begin
        data_bytes = {fill_idx_q, 1'b0};
        tail_off   = {1'b0, byte_idx_q} - data_bytes;
        rd_word    = buffer[byte_idx_q[8:1]];
        sd_din     = 8'h00;
        if (state_q == StSend) begin
            if ({1'b0, byte_idx_q} < data_bytes) begin
                sd_din = byte_idx_q[0] ? rd_word[15:8] : rd_word[7:0];
            end else if (mark_here_q && tail_off < 10'd4) begin
                case (tail_off[1:0])
                    2'd0:    sd_din = 8'hFE;
                    2'd1:    sd_din = 8'hE1;
                    2'd2:    sd_din = 8'hDE;
                    default: sd_din = 8'hAD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Scoreboard bench for sd_sector_writer: stimulus pushes expected bytes and sector
// addresses, a monitor pops and compares on every sd_wr pulse and byte strobe edge.
module tb_sd_sector_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] start_address = '0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        sd_ready = 1'b1;
    logic        sd_ready_for_next_byte = 1'b0;
    logic        sd_wr;
    logic [7:0]  sd_din;
    logic [31:0] sd_address;
    logic        busy;
    logic        done;
    logic [15:0] sectors_written;

    sd_sector_writer #(.ADDR_INC(512)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .stop                   (stop),
        .start_address          (start_address),
        .sample_in              (sample_in),
        .sample_valid           (sample_valid),
        .sample_ready           (sample_ready),
        .sd_ready               (sd_ready),
        .sd_ready_for_next_byte (sd_ready_for_next_byte),
        .sd_wr                  (sd_wr),
        .sd_din                 (sd_din),
        .sd_address             (sd_address),
        .busy                   (busy),
        .done                   (done),
        .sectors_written        (sectors_written)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [31:0] addr_q[$];
    int         wr_count = 0;
    int         byte_num = 0;
    int         ctl_hold = 1;
    int         ctl_limit = 100000;
    bit         ctl_aborted = 1'b0;
    bit         strobe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: sector address on each sd_wr, byte value on each strobe rising edge.
    initial begin
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (sd_wr) begin
                wr_count++;
                byte_num = 0;
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sd_wr_unexpected: got 0x%0h expected none", sd_address);
                end else begin
                    check("sd_address_at_wr", sd_address, addr_q.pop_front());
                end
            end
            if (sd_ready_for_next_byte && !strobe_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL byte_unexpected: got 0x%0h expected none", sd_din);
                end else begin
                    eb = exp_q.pop_front();
                    check($sformatf("byte%0d", byte_num), {24'd0, sd_din}, {24'd0, eb});
                end
                byte_num++;
            end
            strobe_prev = sd_ready_for_next_byte;
        end
    end

    // SD controller model: on sd_wr drop ready, strobe 512 bytes, then raise ready.
    initial begin
        forever begin
            @(negedge clk);
            if (sd_wr) begin
                @(posedge clk);
                #1;
                sd_ready = 1'b0;
                for (int b = 0; b < 512; b++) begin
                    if (b == ctl_limit) begin
                        ctl_aborted = 1'b1;
                        break;
                    end
                    sd_ready_for_next_byte = 1'b1;
                    repeat (ctl_hold) begin
                        @(posedge clk);
                        #1;
                    end
                    sd_ready_for_next_byte = 1'b0;
                    @(posedge clk);
                    #1;
                end
                repeat (2) @(posedge clk);
                #1;
                sd_ready = 1'b1;
            end
        end
    end

    task automatic push_word(input logic [15:0] s);
        exp_q.push_back(s[7:0]);
        exp_q.push_back(s[15:8]);
    endtask

    task automatic push_marker();
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hDE);
        exp_q.push_back(8'hAD);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'h00);
    endtask

    // All driving tasks start and end at posedge+1.
    task automatic pulse_start(input logic [31:0] a);
        start_address = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] s, input bit with_stop);
        int n = 0;
        push_word(s);
        sample_in = s;
        sample_valid = 1'b1;
        stop = with_stop;
        @(negedge clk);
        while (!sample_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) fail_timeout("sample_accept");
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail_timeout("wait_done");
        check("done", {31'd0, done}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("queues_drained", exp_q.size() + addr_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sd_wr"}, {31'd0, sd_wr}, 32'd0);
        check({tag, "_sample_ready"}, {31'd0, sample_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_sd_din"}, {24'd0, sd_din}, 32'd0);
        check({tag, "_sd_address"}, sd_address, 32'd0);
        check({tag, "_sectors"}, {16'd0, sectors_written}, 32'd0);
    endtask

    initial begin
        int n;
        int wr_before;
        #1 reset = 1'b1;
        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Full sector, strobe held 5 cycles per byte, then a marker-only sector.
        ctl_hold = 5;
        addr_q.push_back(32'h1000);
        pulse_start(32'h1000);
        check("start_clears_sectors", {16'd0, sectors_written}, 32'd0);
        check("start_latches_addr", sd_address, 32'h1000);
        for (int i = 1; i <= 256; i++) send_sample(16'(i), 1'b0);
        n = 0;
        while (sectors_written != 16'd1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("full_sectors", {16'd0, sectors_written}, 32'd1);
        check("full_next_addr", sd_address, 32'h1200);
        check("full_back_to_fill", {31'd0, sample_ready}, 32'd1);
        check("full_wr_count", wr_count, 32'd1);
        @(posedge clk);
        #1;
        addr_q.push_back(32'h1200);
        push_marker();
        push_zeros(508);
        pulse_stop();
        wait_done();
        check("full_end_sectors", {16'd0, sectors_written}, 32'd2);
        check("full_end_addr", sd_address, 32'h1400);
        ctl_hold = 1;

        // Short recording from DONE; stop coincides with the last sample; address wraps.
        @(posedge clk);
        #1;
        addr_q.push_back(32'hFFFF_FE00);
        pulse_start(32'hFFFF_FE00);
        check("restart_clears_sectors", {16'd0, sectors_written}, 32'd0);
        send_sample(16'h1234, 1'b0);
        send_sample(16'h5678, 1'b0);
        send_sample(16'h9ABC, 1'b1);
        push_marker();
        push_zeros(502);
        wait_done();
        check("short_sectors", {16'd0, sectors_written}, 32'd1);
        check("short_addr_wrap", sd_address, 32'h0000_0000);

        // 255 samples: marker spills into a second sector.
        @(posedge clk);
        #1;
        addr_q.push_back(32'h0002_0000);
        addr_q.push_back(32'h0002_0200);
        pulse_start(32'h0002_0000);
        for (int i = 0; i < 255; i++) send_sample({8'(i), ~8'(i)}, 1'b0);
        push_zeros(2);
        push_marker();
        push_zeros(508);
        pulse_stop();
        wait_done();
        check("ovf_sectors", {16'd0, sectors_written}, 32'd2);
        check("ovf_addr", sd_address, 32'h0002_0400);

        // Stop with nothing filled still yields one marker sector.
        @(posedge clk);
        #1;
        addr_q.push_back(32'h300);
        pulse_start(32'h300);
        push_marker();
        push_zeros(508);
        pulse_stop();
        wait_done();
        check("empty_sectors", {16'd0, sectors_written}, 32'd1);
        check("empty_addr", sd_address, 32'h500);

        // Reset after 100 bytes of a sector, then a clean restart.
        @(posedge clk);
        #1;
        ctl_limit = 100;
        addr_q.push_back(32'h4000);
        pulse_start(32'h4000);
        for (int i = 0; i < 256; i++) send_sample(16'hC000 + 16'(i), 1'b0);
        n = 0;
        while (!ctl_aborted && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!ctl_aborted) fail_timeout("wait_100_bytes");
        check("mid_send_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        exp_q.delete();
        addr_q.delete();
        ctl_limit = 100000;
        ctl_aborted = 1'b0;
        wr_before = wr_count;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("no_wr_after_reset", wr_count, wr_before);
        check("idle_after_reset", {31'd0, busy}, 32'd0);
        addr_q.push_back(32'h8000);
        pulse_start(32'h8000);
        check("restart_addr", sd_address, 32'h8000);
        send_sample(16'h0BEE, 1'b0);
        push_marker();
        push_zeros(506);
        pulse_stop();
        wait_done();
        check("restart_sectors", {16'd0, sectors_written}, 32'd1);
        check("restart_end_addr", sd_address, 32'h8200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
